// File: rtl/key_cond_pkg.sv
// Shared definitions for the key pulse conditioner: FSM state encodings and
// the counter-width helper used to size the debounce/repeat counters.
package key_cond_pkg;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_DB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_DB_RELEASE = 2'd3;

  // One spare bit above the largest terminal count keeps every compare in range.
  function automatic int cnt_width(input int debounce, input int repeat_delay,
                                   input int repeat_period);
    int largest;
    largest = debounce;
    if (repeat_delay > largest) largest = repeat_delay;
    if (repeat_period > largest) largest = repeat_period;
    return $clog2(largest) + 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset
// value so a key can come out of reset as "released".
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignment so both flops sample
  // the pre-edge values; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces an active-low pushbutton and emits a one-cycle add strobe with the
// synchronised switch value, auto-repeating while the key stays held.
module key_pulse_conditioner
  import key_cond_pkg::*;
#(
  parameter int WIDTH         = 10,
  parameter int DEBOUNCE      = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Key_n,
  input  logic [WIDTH-1:0] SW,
  output logic             Valid,
  output logic [WIDTH-1:0] Data,
  output logic             Held
);

  localparam int CW = cnt_width(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic             key_s;
  logic [WIDTH-1:0] sw_s;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    dcnt_q, dcnt_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic             rep_q, rep_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rpt_last;

  sync2 #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync_key (
    .clk   (Clock),
    .rst_n (Resetn),
    .d_i   (Key_n),
    .q_o   (key_s)
  );

  sync2 #(.WIDTH(WIDTH), .RESET_VAL('0)) u_sync_sw (
    .clk   (Clock),
    .rst_n (Resetn),
    .d_i   (SW),
    .q_o   (sw_s)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    rcnt_d   = rcnt_q;
    rep_d    = rep_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    rpt_last = rep_q ? RP_LAST : RD_LAST;

    case (state_q)
      ST_IDLE: begin
        if (!key_s) begin
          state_d = ST_DB_PRESS;
          dcnt_d  = '0;
        end
      end
      ST_DB_PRESS: begin
        if (key_s) begin
          state_d = ST_IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_HELD;
          valid_d = 1'b1;
          data_d  = sw_s;
          rcnt_d  = '0;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        // rcnt is deliberately kept across a release bounce so repeats resume.
        if (key_s) begin
          state_d = ST_DB_RELEASE;
          dcnt_d  = '0;
        end else if (REPEAT_DELAY != 0) begin
          if (rcnt_q == rpt_last) begin
            valid_d = 1'b1;
            data_d  = sw_s;
            rcnt_d  = '0;
            rep_d   = 1'b1;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
      end
      ST_DB_RELEASE: begin
        if (!key_s) begin
          state_d = ST_HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d = ST_IDLE;
          rep_d   = 1'b0;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      rep_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      rep_q   <= rep_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign Valid = valid_q;
  assign Data  = data_q;
  assign Held  = (state_q == ST_HELD) || (state_q == ST_DB_RELEASE);

endmodule
